// File: rtl/mult_sched_pkg.sv
// rtl/mult_sched_pkg.sv - shared types and widths for the multiplier scheduler
//
// Holds the FSM state encoding, operand/result widths and the default
// WAIT/DRAIN timeout used by mult_sched and its testbench.
package mult_sched_pkg;

    localparam int OP_W        = 16;
    localparam int RES_W       = 32;
    localparam int TIMEOUT_DEF = 64;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

endpackage

// File: rtl/mult_rr_arb.sv
// rtl/mult_rr_arb.sv - round-robin selector for the multiplier scheduler
//
// Ports:
//   req_i  - request vector, one bit per requester
//   last_i - index of the previous grantee; search starts at last_i + 1
//   gnt_o  - one-hot grant (all zero when no request)
//   idx_o  - index of the granted requester (0 when no request)
module mult_rr_arb #(
    parameter int NREQ = 2,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   last_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   idx_o
);

    logic          found;
    logic [IW-1:0] cand;

    // Walk the requesters in rotated order; the previous grantee is visited
    // last, so it only wins again when nobody else is asking.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(last_i) + k) % NREQ);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/mult_sched.sv
// rtl/mult_sched.sv - shares one external multiplier among NREQ requesters
//
// Ports:
//   clk, reset               - clock, asynchronous active-low reset
//   req_valid/req_a/req_b    - per-requester level requests and packed operands
//   req_ready                - one-cycle accept pulse to the granted requester
//   resp_valid/resp_result/resp_err - one-cycle response pulse, product, timeout flag
//   mul_init/mul_op_a/mul_op_b      - start pulse and operands to the multiplier
//   mul_done/mul_result      - multiplier completion level and product
module mult_sched
    import mult_sched_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*OP_W-1:0] req_a,
    input  logic [NREQ*OP_W-1:0] req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      resp_valid,
    output logic [RES_W-1:0]     resp_result,
    output logic                 resp_err,
    output logic                 mul_init,
    output logic [OP_W-1:0]      mul_op_a,
    output logic [OP_W-1:0]      mul_op_b,
    input  logic                 mul_done,
    input  logic [RES_W-1:0]     mul_result
);

    localparam int            IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int            CW  = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

    state_e            state_q, state_d;
    logic [IW-1:0]     last_q, last_d;
    logic [NREQ-1:0]   ready_q, ready_d;
    logic [OP_W-1:0]   op_a_q, op_a_d;
    logic [OP_W-1:0]   op_b_q, op_b_d;
    logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;
    logic [NREQ-1:0]   resp_valid_q, resp_valid_d;
    logic [RES_W-1:0]  resp_result_q, resp_result_d;
    logic              resp_err_q, resp_err_d;

    logic [NREQ-1:0]   gnt;
    logic [IW-1:0]     gnt_idx;

    mult_rr_arb #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req_i  (req_valid),
        .last_i (last_q),
        .gnt_o  (gnt),
        .idx_o  (gnt_idx)
    );

    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        ready_d       = '0;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        cnt_inc       = (cnt_q >= TMO) ? TMO : cnt_q + 1'b1;
        cnt_d         = cnt_inc;
        resp_valid_d  = '0;
        resp_result_d = '0;
        resp_err_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A mul_done still high here is left over from an earlier
                // operation (or one cut short by reset); starting now would
                // let that stale level be mistaken for the new result.
                if ((|req_valid) && !mul_done) begin
                    ready_d = gnt;
                    last_d  = gnt_idx;
                    op_a_d  = req_a[int'(gnt_idx)*OP_W +: OP_W];
                    op_b_d  = req_b[int'(gnt_idx)*OP_W +: OP_W];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mul_done) begin
                    resp_valid_d[last_q] = 1'b1;
                    resp_result_d        = mul_result;
                    cnt_d                = '0;
                    state_d              = S_DRAIN;
                end else if (cnt_inc == TMO) begin
                    resp_valid_d[last_q] = 1'b1;
                    resp_err_d           = 1'b1;
                    cnt_d                = '0;
                    state_d              = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!mul_done || (cnt_inc == TMO)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            // Last grantee = NREQ-1 makes requester 0 first in line.
            last_q        <= IW'(NREQ - 1);
            ready_q       <= '0;
            op_a_q        <= '0;
            op_b_q        <= '0;
            cnt_q         <= '0;
            resp_valid_q  <= '0;
            resp_result_q <= '0;
            resp_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            ready_q       <= ready_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            cnt_q         <= cnt_d;
            resp_valid_q  <= resp_valid_d;
            resp_result_q <= resp_result_d;
            resp_err_q    <= resp_err_d;
        end
    end

    // req_ready is registered and so coincides with the single ISSUE cycle,
    // which is also the one cycle mul_init is decoded high.
    assign req_ready   = ready_q;
    assign mul_init    = (state_q == S_ISSUE);
    assign mul_op_a    = op_a_q;
    assign mul_op_b    = op_b_q;
    assign resp_valid  = resp_valid_q;
    assign resp_result = resp_result_q;
    assign resp_err    = resp_err_q;

endmodule

// File: tb/tb_mult_sched.sv
// tb/tb_mult_sched.sv - scoreboard testbench for mult_sched
module tb_mult_sched;

    localparam int NREQ = 3;
    localparam int TMO  = 20;

    typedef struct {
        int          idx;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] res;
        logic        err;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*16-1:0]   req_a;
    logic [NREQ*16-1:0]   req_b;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      resp_valid;
    logic [31:0]          resp_result;
    logic                 resp_err;
    logic                 mul_init;
    logic [15:0]          mul_op_a;
    logic [15:0]          mul_op_b;
    logic                 mul_done;
    logic [31:0]          mul_result;

    int          total = 0;
    int          bad = 0;
    int          n_resp = 0;
    int          n_grant = 0;
    int          n_init = 0;
    int          n_exp = 0;
    int          acc_cnt[NREQ];
    int          acc_seen[NREQ];
    int          glog[$];
    exp_t        sb[$];
    logic [31:0] last_res = '0;
    logic        last_err = 1'b0;
    int          lat_min = 1;
    int          lat_max = 1;
    int          hold_min = 2;
    int          hold_max = 2;
    logic        dead = 1'b0;

    always #5 clk = ~clk;

    mult_sched #(
        .NREQ    (NREQ),
        .TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ready   (req_ready),
        .resp_valid  (resp_valid),
        .resp_result (resp_result),
        .resp_err    (resp_err),
        .mul_init    (mul_init),
        .mul_op_a    (mul_op_a),
        .mul_op_b    (mul_op_b),
        .mul_done    (mul_done),
        .mul_result  (mul_result)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural multiplier: random latency after mul_init, then holds
    // mul_done for a while; reset aborts it like the real block would.
    initial begin : mul_model
        int          st;
        int          cnt;
        logic [15:0] pa;
        logic [15:0] pb;
        st = 0; cnt = 0; pa = '0; pb = '0;
        mul_done = 1'b0;
        mul_result = '0;
        forever begin
            @(posedge clk);
            #1;
            if (reset !== 1'b1) begin
                st = 0;
                mul_done = 1'b0;
                mul_result = '0;
            end else begin
                case (st)
                    0: if (mul_init && !dead) begin
                        pa = mul_op_a;
                        pb = mul_op_b;
                        cnt = $urandom_range(lat_max, lat_min);
                        st = 1;
                    end
                    1: if (cnt == 0) begin
                        mul_done = 1'b1;
                        mul_result = 32'(pa) * 32'(pb);
                        cnt = $urandom_range(hold_max, hold_min);
                        st = 2;
                    end else begin
                        cnt--;
                    end
                    default: if (cnt <= 1) begin
                        mul_done = 1'b0;
                        mul_result = '0;
                        st = 0;
                    end else begin
                        cnt--;
                    end
                endcase
            end
        end
    end

    // Monitor: predicts each grant from the round-robin rule, pushes the
    // expected response, and pops/compares when resp_valid pulses.
    initial begin : monitor
        int              cyc;
        int              init_cyc;
        int              m_last;
        int              g_exp;
        int              g_act;
        logic            prev_done;
        logic            seen_rst;
        logic [NREQ-1:0] oh;
        exp_t            e;
        cyc = 0; init_cyc = 0; m_last = NREQ - 1;
        prev_done = 1'b0; seen_rst = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            if (reset === 1'b0) begin
                seen_rst = 1'b1;
                chk("rst_ctl", 64'({req_ready, resp_valid, resp_err, mul_init}), 64'd0);
                chk("rst_result", 64'(resp_result), 64'd0);
                chk("rst_ops", 64'({mul_op_a, mul_op_b}), 64'd0);
                sb.delete();
                m_last = NREQ - 1;
            end else if (seen_rst) begin
                if (mul_init) n_init++;
                chk("init_with_ready", 64'(mul_init), 64'(|req_ready));
                if (resp_valid == '0)
                    chk("idle_resp_zero", 64'({resp_err, resp_result}), 64'd0);

                if (req_ready != '0) begin
                    chk("ready_onehot", 64'($countones(req_ready)), 64'd1);
                    g_exp = -1;
                    for (int k = 1; k <= NREQ; k++) begin
                        int c;
                        c = (m_last + k) % NREQ;
                        if (g_exp < 0 && req_valid[c]) g_exp = c;
                    end
                    g_act = -1;
                    for (int i = 0; i < NREQ; i++)
                        if (g_act < 0 && req_ready[i]) g_act = i;
                    chk("grant_idx", 64'(g_act), 64'(g_exp));
                    chk("grant_stale_done", 64'(prev_done), 64'd0);
                    chk("grant_overlap", 64'(sb.size()), 64'd0);
                    if (g_act >= 0) begin
                        e.idx = g_act;
                        e.a   = req_a[g_act*16 +: 16];
                        e.b   = req_b[g_act*16 +: 16];
                        e.err = dead;
                        e.res = dead ? 32'd0 : 32'(e.a) * 32'(e.b);
                        chk("op_a_latch", 64'(mul_op_a), 64'(e.a));
                        chk("op_b_latch", 64'(mul_op_b), 64'(e.b));
                        sb.push_back(e);
                        m_last = g_act;
                        acc_cnt[g_act]++;
                        glog.push_back(g_act);
                        n_grant++;
                        init_cyc = cyc;
                    end
                end

                if (resp_valid != '0) begin
                    chk("resp_onehot", 64'($countones(resp_valid)), 64'd1);
                    if (sb.size() == 0) begin
                        chk("resp_unexpected", 64'(resp_valid), 64'd0);
                    end else begin
                        e = sb.pop_front();
                        oh = '0;
                        oh[e.idx] = 1'b1;
                        chk("resp_idx", 64'(resp_valid), 64'(oh));
                        chk("resp_result", 64'(resp_result), 64'(e.res));
                        chk("resp_err", 64'(resp_err), 64'(e.err));
                        chk("ops_held", 64'({mul_op_a, mul_op_b}), 64'({e.a, e.b}));
                        if (e.err)
                            chk("timeout_latency", 64'(cyc - (init_cyc + 1)), 64'(TMO));
                    end
                    last_res = resp_result;
                    last_err = resp_err;
                    n_resp++;
                end
            end
            prev_done = mul_done;
        end
    end

    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) begin
            if (acc_seen[i] != acc_cnt[i]) begin
                acc_seen[i] = acc_cnt[i];
                req_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic raise(input int i, input logic [15:0] a, input logic [15:0] b);
        req_a[i*16 +: 16] = a;
        req_b[i*16 +: 16] = b;
        req_valid[i] = 1'b1;
        n_exp++;
    endtask

    task automatic wait_resp(input string name, input int budget);
        int k;
        k = 0;
        while (n_resp < n_exp && k < budget) begin
            tick();
            k++;
        end
        chk(name, 64'(n_resp), 64'(n_exp));
    endtask

    task automatic wait_grant(input string name, input int g0, input int budget);
        int k;
        k = 0;
        while (n_grant == g0 && k < budget) begin
            tick();
            k++;
        end
        chk(name, 64'(n_grant - g0), 64'd1);
    endtask

    task automatic do_reset();
        req_valid = '0;
        reset = 1'b0;
        #1;
        chk("rst_now_ctl", 64'({req_ready, resp_valid, resp_err, mul_init}), 64'd0);
        chk("rst_now_result", 64'(resp_result), 64'd0);
        chk("rst_now_ops", 64'({mul_op_a, mul_op_b}), 64'd0);
        tick();
        tick();
        reset = 1'b1;
        n_exp = n_resp;
        for (int i = 0; i < NREQ; i++) acc_seen[i] = acc_cnt[i];
    endtask

    function automatic logic [15:0] rnd_op();
        int s;
        s = $urandom_range(0, 5);
        if (s == 0) return 16'h0000;
        if (s == 1) return 16'hFFFF;
        return 16'($urandom());
    endfunction

    initial begin : driver
        int g0;
        int i0;
        int issued;
        int k;
        reset = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        tick();
        do_reset();
        tick();

        // basic 3 x 5
        raise(0, 16'd3, 16'd5);
        wait_resp("d1_done", 200);
        chk("d1_result", 64'(last_res), 64'd15);
        chk("d1_err", 64'(last_err), 64'd0);

        // simultaneous requests after reset: 0 then 1, twice
        do_reset();
        tick();
        for (int rep = 0; rep < 2; rep++) begin
            g0 = glog.size();
            raise(0, rnd_op(), rnd_op());
            raise(1, rnd_op(), rnd_op());
            wait_resp("d2_done", 400);
            chk("d2_count", 64'(glog.size() - g0), 64'd2);
            chk("d2_first", 64'((glog.size() > g0) ? glog[g0] : -1), 64'd0);
            chk("d2_second", 64'((glog.size() > g0 + 1) ? glog[g0 + 1] : -1), 64'd1);
        end

        // operand corners
        raise(0, 16'hFFFF, 16'hFFFF);
        wait_resp("d3_max_done", 200);
        chk("d3_max_result", 64'(last_res), 64'h0000_0000_FFFE_0001);
        raise(1, 16'h1234, 16'h0000);
        wait_resp("d3_zero_done", 200);
        chk("d3_zero_result", 64'(last_res), 64'd0);

        // multiplier never answers
        dead = 1'b1;
        raise(2, 16'd7, 16'd7);
        wait_resp("d4_done", 200);
        chk("d4_err", 64'(last_err), 64'd1);
        chk("d4_result", 64'(last_res), 64'd0);
        dead = 1'b0;

        // withdrawn request is never granted
        lat_min = 10; lat_max = 10;
        g0 = n_grant;
        raise(0, 16'd2, 16'd9);
        wait_grant("d5_grant", g0, 50);
        req_a[2*16 +: 16] = 16'd4;
        req_b[2*16 +: 16] = 16'd4;
        req_valid[2] = 1'b1;
        repeat (3) tick();
        req_valid[2] = 1'b0;
        wait_resp("d5_done", 200);
        repeat (8) tick();
        chk("d5_withdraw_no_grant", 64'(n_grant - g0), 64'd1);

        // reset while waiting on the multiplier
        lat_min = 25; lat_max = 25;
        g0 = n_grant;
        raise(0, 16'd11, 16'd13);
        wait_grant("d6_grant", g0, 50);
        repeat (4) tick();
        do_reset();
        tick();
        lat_min = 1; lat_max = 1;
        raise(1, 16'd7, 16'd9);
        wait_resp("d6_after_done", 200);
        chk("d6_after_result", 64'(last_res), 64'd63);

        // new request while mul_done still high in DRAIN
        lat_min = 2; lat_max = 2;
        hold_min = 30; hold_max = 30;
        raise(0, 16'd100, 16'd200);
        wait_resp("d7_first_done", 200);
        i0 = n_init;
        raise(1, 16'd300, 16'd5);
        wait_resp("d7_second_done", 300);
        chk("d7_second_result", 64'(last_res), 64'd1500);
        chk("d7_single_init", 64'(n_init - i0), 64'd1);

        // randomized traffic
        lat_min = 0; lat_max = 6;
        hold_min = 1; hold_max = 6;
        issued = 0;
        k = 0;
        while (issued < 150 && k < 20000) begin
            tick();
            k++;
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && issued < 150 && $urandom_range(0, 2) == 0) begin
                    raise(i, rnd_op(), rnd_op());
                    issued++;
                end
            end
        end
        wait_resp("rand_done", 20000);
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/mult_sched.md
MULT_SCHED -- requirements
Module: mult_sched

Interface
REQ-001 SHALL have parameter NREQ, default 2: number of requesters sharing the multiplier.
REQ-002 SHALL have parameter TIMEOUT, default 64: maximum cycles spent in WAIT or DRAIN.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port req_valid, input, NREQ bits: per-requester request; level-held until accepted.
REQ-006 SHALL have port req_a, input, NREQ*16 bits: operand A, requester i in bits [16i+15:16i].
REQ-007 SHALL have port req_b, input, NREQ*16 bits: operand B, same packing as req_a.
REQ-008 SHALL have port req_ready, output, NREQ bits: one-cycle pulse, request accepted.
REQ-009 SHALL have port resp_valid, output, NREQ bits: one-cycle pulse, result available for requester i.
REQ-010 SHALL have port resp_result, output, 32 bits: product, valid while any resp_valid bit is high.
REQ-011 SHALL have port resp_err, output, 1 bit: timeout flag, valid while any resp_valid bit is high.
REQ-012 SHALL have port mul_init, output, 1 bit: start pulse to the multiplier.
REQ-013 SHALL have ports mul_op_a and mul_op_b, outputs, 16 bits each: multiplier operands.
REQ-014 SHALL have port mul_done, input, 1 bit: multiplier completion flag; high for many cycles.
REQ-015 SHALL have port mul_result, input, 32 bits: multiplier product, valid while mul_done is high.

Function
REQ-016 SHALL implement the states IDLE, ISSUE, WAIT and DRAIN.
REQ-017 In IDLE, when any req_valid bit is high, SHALL select the grantee g by round-robin, starting the search at the index after the last grantee.
REQ-018 On that grant SHALL pulse req_ready[g], latch req_a/req_b slice g into the mul_op_a/mul_op_b registers, and go to ISSUE.
REQ-019 mul_op_a and mul_op_b SHALL stay constant from grant until the next grant.
REQ-020 In ISSUE SHALL assert mul_init for exactly one cycle, clear the cycle counter, and go to WAIT.
REQ-021 In WAIT, mul_done=1 SHALL cause a resp_valid[g] pulse with resp_result=mul_result and resp_err=0, then a move to DRAIN.
REQ-022 In WAIT, if the counter reaches TIMEOUT without mul_done, SHALL pulse resp_valid[g] with resp_result=0 and resp_err=1, then go to DRAIN.
REQ-023 In DRAIN SHALL wait for mul_done=0, or TIMEOUT cycles, then go to IDLE; no new grant is made before IDLE.
REQ-024 Requests SHALL be accepted only in IDLE; req_valid dropped before req_ready is treated as withdrawn, with no grant.
REQ-025 If mul_done is already high in IDLE (stale), SHALL not grant until mul_done=0.
REQ-026 At most one req_ready bit and one resp_valid bit SHALL be high in any cycle.
REQ-027 resp_result and resp_err SHALL be 0 whenever no resp_valid bit is high.
REQ-028 The counter SHALL be wide enough for TIMEOUT and SHALL saturate, never wrap.

Reset
REQ-029 reset=0 SHALL immediately force state IDLE and round-robin pointer 0 (requester 0 highest priority), and drive all outputs to 0.
REQ-030 Reset mid-operation SHALL drop the transaction silently, with no resp_valid; in DRAIN-equivalent handling, the first grant after release waits for mul_done=0.

Structure
REQ-031 Shared package mult_sched_pkg SHALL hold the state encoding, operand width 16, result width 32 and the default TIMEOUT.
REQ-032 Round-robin selection SHALL be one sub-module, mult_rr_arb (inputs: request vector, last grantee; outputs: one-hot grant, grant index).
REQ-033 The multiplier SHALL be instantiated outside this block; the integrator inverts reset for the multiplier's active-high reset.

Verification
REQ-034 Directed test: req0 with a=3, b=5 -> one req_ready[0] pulse, one mul_init pulse, then resp_valid[0] with result 15 and err 0.
REQ-035 Directed test: req0 and req1 together after reset -> req0 served first, then req1 with no overlap; a repeat of both -> same order (pointer advanced past 1).
REQ-036 Directed test: a=0xFFFF, b=0xFFFF -> result 0xFFFE0001; a=0x1234, b=0 -> result 0.
REQ-037 Directed test: mul_done tied 0 -> resp_valid with err=1 and result 0 exactly TIMEOUT cycles after WAIT entry, then return to IDLE.
REQ-038 Directed test: reset asserted during WAIT -> all outputs 0 the same cycle, no resp_valid, and the next request completes correctly.
REQ-039 Directed test: new req1 arrives while mul_done is still high in DRAIN -> grant only after mul_done falls, with exactly one mul_init.
